// File: rtl/mem_load_stage.sv
// Memory-load pipeline stage.
// Holds one instruction. Loads wait here for the data-cache read response,
// which is formatted (lane select, sign/zero extension, LWL/LWR merge) into
// the write-back result. Non-loads pass straight through. Responses that
// belong to loads killed by a flush are counted in drop_cnt and discarded.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 kill the held instruction and any pending load
//   m1s_to_ms_valid       upstream valid;  ms_allowin: stage can accept
//   in_*                  instruction fields registered on accept
//   dcache_rvalid/rdata   one-cycle read-response pulse and its data
//   ws_allowin            downstream can accept; ms_to_ws_valid: result valid
//   out_*                 held instruction fields and final write-back data
//   fwd_dest/result/ok    bypass address (0 when empty), data, data-final flag
module mem_load_stage #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int DEST_W = 5,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              m1s_to_ms_valid,
  output logic              ms_allowin,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_gr_we,
  input  logic              in_res_from_mem,
  input  logic [3:0]        in_load_op,
  input  logic [OFF_W-1:0]  in_addr_lo,
  input  logic [XLEN-1:0]   in_rt_value,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic              in_ex,
  input  logic              in_cp0_sel,
  input  logic [XLEN-1:0]   in_cp0_data,
  input  logic              dcache_rvalid,
  input  logic [XLEN-1:0]   dcache_rdata,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_gr_we,
  output logic              out_ex,
  output logic [XLEN-1:0]   out_result,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [XLEN-1:0]   fwd_result,
  output logic              fwd_data_ok
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

  state_t              state;
  logic [1:0]          drop_cnt;
  logic                res_from_mem_q, ex_q, cp0_sel_q;
  logic [3:0]          load_op_q;
  logic [OFF_W-1:0]    addr_lo_q;
  logic [31:0]         rt_q;
  logic [XLEN-1:0]     alu_q, cp0_q, data_q;

  logic                accept, rsp_take, rsp_drop, kill_wait;

  always_comb begin
    ms_to_ws_valid = (state == S_READY);
    ms_allowin     = (state == S_EMPTY) || (ms_to_ws_valid && ws_allowin);
    accept         = m1s_to_ms_valid && ms_allowin && !flush;
    rsp_drop       = dcache_rvalid && (drop_cnt != 2'd0);
    rsp_take       = dcache_rvalid && (drop_cnt == 2'd0) && (state == S_WAIT);
    // A response consumed in the flush cycle belongs to the killed load
    // itself, so nothing is left outstanding for it.
    kill_wait      = flush && (state == S_WAIT) && !rsp_take;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_EMPTY;
      drop_cnt       <= '0;
      out_pc         <= '0;
      out_dest       <= '0;
      out_gr_we      <= 1'b0;
      res_from_mem_q <= 1'b0;
      load_op_q      <= '0;
      addr_lo_q      <= '0;
      rt_q           <= '0;
      alu_q          <= '0;
      out_ex         <= 1'b0;
      cp0_sel_q      <= 1'b0;
      cp0_q          <= '0;
      data_q         <= '0;
    end else begin
      if (kill_wait && !rsp_drop) begin
        if (drop_cnt != 2'd3) drop_cnt <= drop_cnt + 2'd1;
      end else if (rsp_drop && !kill_wait) begin
        drop_cnt <= drop_cnt - 2'd1;
      end

      if (rsp_take) data_q <= dcache_rdata;

      if (flush) begin
        state <= S_EMPTY;
      end else if (accept) begin
        out_pc         <= in_pc;
        out_dest       <= in_dest;
        out_gr_we      <= in_gr_we;
        res_from_mem_q <= in_res_from_mem;
        load_op_q      <= in_load_op;
        addr_lo_q      <= in_addr_lo;
        rt_q           <= in_rt_value[31:0];
        alu_q          <= in_alu_result;
        out_ex         <= in_ex;
        cp0_sel_q      <= in_cp0_sel;
        cp0_q          <= in_cp0_data;
        state          <= (in_res_from_mem && !in_ex) ? S_WAIT : S_READY;
      end else if (state == S_READY && ws_allowin) begin
        state <= S_EMPTY;
      end else if (rsp_take) begin
        state <= S_READY;
      end
    end
  end

  // Load formatting: lanes are floor-aligned to their own size.
  logic [OFF_W-1:0] half_off, word_off;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      lane_w, lwl, lwr;
  logic [4:0]       lsh, rsh;
  logic [XLEN-1:0]  fmt_data;

  always_comb begin
    half_off = addr_lo_q & ~OFF_W'(1);
    word_off = addr_lo_q & ~OFF_W'(3);
    lane_b   = 8'(data_q >> {addr_lo_q, 3'b000});
    lane_h   = 16'(data_q >> {half_off, 3'b000});
    lane_w   = 32'(data_q >> {word_off, 3'b000});
    // LWL shifts left by 3-b bytes, LWR right by b bytes; rt fills the rest.
    lsh      = {~addr_lo_q[1:0], 3'b000};
    rsh      = {addr_lo_q[1:0], 3'b000};
    lwl      = (lane_w << lsh) | (rt_q & ~(32'hFFFF_FFFF << lsh));
    lwr      = (lane_w >> rsh) | (rt_q & ~(32'hFFFF_FFFF >> rsh));
    case (load_op_q)
      4'd0:    fmt_data = XLEN'($signed(lane_b));
      4'd1:    fmt_data = XLEN'(lane_b);
      4'd2:    fmt_data = XLEN'($signed(lane_h));
      4'd3:    fmt_data = XLEN'(lane_h);
      4'd4:    fmt_data = XLEN'($signed(lane_w));
      4'd5:    fmt_data = (XLEN == 32) ? XLEN'($signed(lane_w)) : XLEN'(lane_w);
      4'd6:    fmt_data = (XLEN == 32) ? XLEN'($signed(lane_w)) : data_q;
      4'd7:    fmt_data = XLEN'($signed(lwl));
      4'd8:    fmt_data = XLEN'($signed(lwr));
      default: fmt_data = data_q;
    endcase
  end

  always_comb begin
    if (res_from_mem_q && !out_ex) out_result = fmt_data;
    else if (cp0_sel_q)            out_result = cp0_q;
    else                           out_result = alu_q;
    fwd_result  = out_result;
    fwd_data_ok = (state == S_READY);
    fwd_dest    = (state != S_EMPTY && out_gr_we) ? out_dest : '0;
  end

endmodule

// File: tb/tb_mem_load_stage.sv
module tb_mem_load_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, v, gr_we, rfm, ex, sel, rvalid, ws;
  logic [31:0] pc;
  logic [4:0]  dest;
  logic [3:0]  op;
  logic [2:0]  addr;
  logic [63:0] rt, alu, cp0, rdata;

  logic        a32, vo32, gwe32, ex32, ok32;
  logic [31:0] pc32, res32, fres32;
  logic [4:0]  d32, fd32;
  logic        a64, vo64, gwe64, ex64, ok64;
  logic [31:0] pc64;
  logic [63:0] res64, fres64;
  logic [4:0]  d64, fd64;

  mem_load_stage #(.XLEN(32), .PC_W(32), .DEST_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .m1s_to_ms_valid(v), .ms_allowin(a32),
    .in_pc(pc), .in_dest(dest), .in_gr_we(gr_we), .in_res_from_mem(rfm),
    .in_load_op(op), .in_addr_lo(addr[1:0]), .in_rt_value(rt[31:0]),
    .in_alu_result(alu[31:0]), .in_ex(ex), .in_cp0_sel(sel), .in_cp0_data(cp0[31:0]),
    .dcache_rvalid(rvalid), .dcache_rdata(rdata[31:0]), .ws_allowin(ws),
    .ms_to_ws_valid(vo32), .out_pc(pc32), .out_dest(d32), .out_gr_we(gwe32),
    .out_ex(ex32), .out_result(res32), .fwd_dest(fd32), .fwd_result(fres32),
    .fwd_data_ok(ok32));

  mem_load_stage #(.XLEN(64), .PC_W(32), .DEST_W(5)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .m1s_to_ms_valid(v), .ms_allowin(a64),
    .in_pc(pc), .in_dest(dest), .in_gr_we(gr_we), .in_res_from_mem(rfm),
    .in_load_op(op), .in_addr_lo(addr), .in_rt_value(rt),
    .in_alu_result(alu), .in_ex(ex), .in_cp0_sel(sel), .in_cp0_data(cp0),
    .dcache_rvalid(rvalid), .dcache_rdata(rdata), .ws_allowin(ws),
    .ms_to_ws_valid(vo64), .out_pc(pc64), .out_dest(d64), .out_gr_we(gwe64),
    .out_ex(ex64), .out_result(res64), .fwd_dest(fd64), .fwd_result(fres64),
    .fwd_data_ok(ok64));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the held instruction plus a queue of outstanding memory
  // reads (oldest first), each flagged if its load was killed by a flush.
  bit          hv, hw;
  logic [31:0] h_pc;
  logic [4:0]  h_dest;
  logic        h_gr_we, h_rfm, h_ex, h_sel;
  logic [3:0]  h_op;
  logic [2:0]  h_addr;
  logic [63:0] h_rt, h_alu, h_cp0, h_data;
  bit          mq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fmt(input int xlen, input logic [3:0] op_i,
                                      input logic [2:0] a, input logic [63:0] d,
                                      input logic [63:0] rtv);
    logic [7:0]  mb[8];
    logic [7:0]  rb[4];
    logic [7:0]  ob[4];
    logic [63:0] r;
    logic [31:0] w;
    int nb, off, hb, wb, b;
    logic [3:0] o;
    nb  = xlen / 8;
    off = int'(a) % nb;
    hb  = (off / 2) * 2;
    wb  = (off / 4) * 4;
    b   = off % 4;
    for (int i = 0; i < 8; i++) mb[i] = d[8*i +: 8];
    for (int i = 0; i < 4; i++) rb[i] = rtv[8*i +: 8];
    w = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
    o = op_i;
    if (xlen == 32 && (o == 4'd5 || o == 4'd6)) o = 4'd4;
    case (o)
      4'd0: r = {{56{mb[off][7]}}, mb[off]};
      4'd1: r = {56'd0, mb[off]};
      4'd2: r = {{48{mb[hb+1][7]}}, mb[hb+1], mb[hb]};
      4'd3: r = {48'd0, mb[hb+1], mb[hb]};
      4'd4: r = {{32{w[31]}}, w};
      4'd5: r = {32'd0, w};
      4'd6: r = d;
      4'd7, 4'd8: begin
        for (int i = 0; i < 4; i++) begin
          if (o == 4'd7) ob[i] = (i >= 3 - b) ? mb[wb + i - (3 - b)] : rb[i];
          else           ob[i] = (i <= 3 - b) ? mb[wb + i + b] : rb[i];
        end
        r = {{32{ob[3][7]}}, ob[3], ob[2], ob[1], ob[0]};
      end
      default: r = d;
    endcase
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic [63:0] exp_res(input int xlen);
    logic [63:0] r;
    if (h_rfm && !h_ex) r = fmt(xlen, h_op, h_addr, h_data, h_rt);
    else                r = h_sel ? h_cp0 : h_alu;
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic int killed_cnt();
    int k = 0;
    foreach (mq[i]) if (mq[i]) k++;
    return k;
  endfunction

  task automatic model_step();
    bit allow, hw_pre, k;
    if (reset) begin
      hv = 0; hw = 0; mq.delete();
      return;
    end
    hw_pre = hw;
    allow  = !hv || (!hw && ws);
    if (rvalid && mq.size() > 0) begin
      k = mq.pop_front();
      if (!k && hv && hw) begin h_data = rdata; hw = 0; end
    end
    if (flush) begin
      if (hv && hw) mq[mq.size()-1] = 1'b1;
      hv = 0; hw = 0;
    end else if (v && allow) begin
      hv = 1; h_pc = pc; h_dest = dest; h_gr_we = gr_we; h_rfm = rfm; h_ex = ex;
      h_sel = sel; h_op = op; h_addr = addr; h_rt = rt; h_alu = alu; h_cp0 = cp0;
      hw = rfm && !ex;
      if (hw) mq.push_back(1'b0);
    end else if (hv && !hw_pre && ws) begin
      hv = 0;
    end
  endtask

  task automatic check_out();
    bit evo;
    logic [4:0] efd;
    #1;
    evo = hv && !hw;
    efd = (hv && h_gr_we) ? h_dest : 5'd0;
    chk("valid32", vo32, evo);
    chk("valid64", vo64, evo);
    chk("allowin32", a32, !hv || (evo && ws));
    chk("allowin64", a64, !hv || (evo && ws));
    chk("fwd_dest32", fd32, efd);
    chk("fwd_dest64", fd64, efd);
    chk("fwd_ok32", ok32, evo);
    chk("fwd_ok64", ok64, evo);
    if (evo) begin
      chk("pc32", pc32, h_pc);
      chk("pc64", pc64, h_pc);
      chk("dest32", d32, h_dest);
      chk("gr_we64", gwe64, h_gr_we);
      chk("ex32", ex32, h_ex);
      chk("ex64", ex64, h_ex);
      chk("result32", res32, exp_res(32));
      chk("result64", res64, exp_res(64));
      chk("fwd_result32", fres32, exp_res(32));
      chk("fwd_result64", fres64, exp_res(64));
    end
  endtask

  // Check outputs for the current cycle, then advance one clock.
  task automatic cycle();
    check_out();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    v = 0; flush = 0; rvalid = 0; ws = 1; reset = 0;
  endtask

  task automatic set_instr(input logic [3:0] o, input logic [2:0] a, input logic r,
                           input logic e, input logic s, input logic [4:0] d,
                           input logic [63:0] rtv, input logic [63:0] alv,
                           input logic [63:0] cpv);
    v = 1; pc = $urandom; gr_we = 1; op = o; addr = a; rfm = r; ex = e; sel = s;
    dest = d; rt = rtv; alu = alv; cp0 = cpv;
  endtask

  initial begin
    idle();
    pc = '0; dest = '0; gr_we = 0; rfm = 0; ex = 0; sel = 0; op = '0; addr = '0;
    rt = '0; alu = '0; cp0 = '0; rdata = '0;

    // Reset, with a flush and a valid instruction pending in the last cycle.
    reset = 1;
    cycle();
    set_instr(4'd0, 3'd0, 0, 0, 0, 5'd9, 64'd0, 64'h55, 64'd0);
    flush = 1;
    cycle();
    chk("rst_valid32", vo32, 1'b0);
    chk("rst_fwd_dest64", fd64, 5'd0);
    chk("rst_fwd_ok32", ok32, 1'b0);
    chk("rst_pc32", pc32, 32'd0);
    chk("rst_result64", res64, 64'd0);
    idle();
    cycle();

    // LB from byte 3, one-cycle response latency.
    set_instr(4'd0, 3'd3, 1, 0, 0, 5'd5, 64'd0, 64'd0, 64'd0);
    cycle();
    chk("lb_wait_valid32", vo32, 1'b0);
    chk("lb_wait_fwd_dest", fd32, 5'd5);
    chk("lb_wait_fwd_ok", ok32, 1'b0);
    v = 0; rvalid = 1; rdata = 64'h0000_0000_80FF_0000;
    cycle();
    rvalid = 0;
    chk("lb_lat_valid32", vo32, 1'b1);
    chk("lb_result32", res32, 32'hFFFF_FF80);
    cycle();

    // LWL, byte offset 1.
    set_instr(4'd7, 3'd1, 1, 0, 0, 5'd6, 64'h0000_0000_AABB_CCDD, 64'd0, 64'd0);
    cycle();
    v = 0; rvalid = 1; rdata = 64'h0000_0000_4433_2211;
    cycle();
    rvalid = 0;
    chk("lwl_result32", res32, 32'h2211_CCDD);
    cycle();

    // Response while downstream stalls: data held, no acceptance.
    set_instr(4'd4, 3'd0, 1, 0, 0, 5'd7, 64'd0, 64'd0, 64'd0);
    ws = 0;
    cycle();
    v = 0; rvalid = 1; rdata = 64'h0000_0000_0000_1234;
    cycle();
    rvalid = 0;
    set_instr(4'd0, 3'd0, 0, 0, 0, 5'd8, 64'd0, 64'h77, 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", vo32, 1'b1);
      chk("stall_result", res32, 32'h1234);
      chk("stall_allowin", a32, 1'b0);
      cycle();
    end
    ws = 1;
    #1 chk("stall_release_allowin", a32, 1'b1);
    cycle();
    chk("stall_next_dest", d32, 5'd8);
    idle();
    cycle();

    // Flush in WAIT: the stale response must not reach the next load.
    set_instr(4'd4, 3'd0, 1, 0, 0, 5'd10, 64'd0, 64'd0, 64'd0);
    cycle();
    v = 0; flush = 1;
    cycle();
    flush = 0;
    set_instr(4'd4, 3'd0, 1, 0, 0, 5'd11, 64'd0, 64'd0, 64'd0);
    cycle();
    v = 0; rvalid = 1; rdata = 64'h0000_0000_0000_DEAD;
    cycle();
    chk("flush_drop_valid", vo32, 1'b0);
    rdata = 64'h0000_0000_0000_BEEF;
    cycle();
    rvalid = 0;
    chk("flush_valid", vo32, 1'b1);
    chk("flush_result32", res32, 32'h0000_BEEF);
    cycle();

    // LWU from the upper word on the 64-bit instance.
    set_instr(4'd5, 3'd4, 1, 0, 0, 5'd12, 64'd0, 64'd0, 64'd0);
    cycle();
    v = 0; rvalid = 1; rdata = 64'hF000_0001_0000_0000;
    cycle();
    rvalid = 0;
    chk("lwu_result64", res64, 64'h0000_0000_F000_0001);
    cycle();

    // Back-to-back ALU / MFC0 results, one per cycle.
    for (int i = 0; i < 4; i++) begin
      set_instr(4'd0, 3'd0, 0, 0, (i == 2), 5'(i + 1), 64'd0, 64'(32'h1000 + i), 64'hC0C0);
      cycle();
      chk("b2b_valid", vo32, 1'b1);
      chk("b2b_fwd_ok", ok32, 1'b1);
      chk("b2b_fwd_dest", fd32, 5'(i + 1));
      chk("b2b_result", res32, (i == 2) ? 32'hC0C0 : 32'h1000 + i);
    end
    idle();
    cycle();

    // Excepting load passes without waiting; stray response in READY ignored.
    set_instr(4'd0, 3'd0, 1, 1, 0, 5'd13, 64'd0, 64'hABCD, 64'd0);
    ws = 0;
    cycle();
    chk("ex_valid", vo32, 1'b1);
    chk("ex_flag", ex64, 1'b1);
    v = 0; rvalid = 1; rdata = 64'h1111;
    cycle();
    rvalid = 0;
    chk("stray_result", res32, 32'hABCD);
    ws = 1;
    cycle();

    // Response in the accept cycle is not attributed to the new load.
    set_instr(4'd4, 3'd0, 1, 0, 0, 5'd14, 64'd0, 64'd0, 64'd0);
    rvalid = 1; rdata = 64'h5555;
    cycle();
    v = 0; rdata = 64'h6666;
    chk("same_cycle_valid", vo32, 1'b0);
    cycle();
    rvalid = 0;
    chk("same_cycle_result", res32, 32'h6666);
    cycle();

    // Reset with a load outstanding: its late response is ignored.
    set_instr(4'd4, 3'd0, 1, 0, 0, 5'd15, 64'd0, 64'd0, 64'd0);
    cycle();
    v = 0; reset = 1;
    cycle();
    reset = 0; rvalid = 1; rdata = 64'h7777;
    cycle();
    rvalid = 0;
    chk("post_reset_valid", vo32, 1'b0);
    chk("post_reset_fwd_dest", fd32, 5'd0);
    cycle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      v      = ($urandom_range(0, 1) == 1);
      pc     = $urandom;
      dest   = 5'($urandom);
      gr_we  = ($urandom_range(0, 3) != 0);
      rfm    = ($urandom_range(0, 1) == 1);
      ex     = ($urandom_range(0, 7) == 0);
      sel    = ($urandom_range(0, 3) == 0);
      op     = 4'($urandom_range(0, 15));
      addr   = 3'($urandom);
      rt     = {$urandom, $urandom};
      alu    = {$urandom, $urandom};
      cp0    = {$urandom, $urandom};
      rdata  = {$urandom, $urandom};
      ws     = ($urandom_range(0, 9) < 7);
      rvalid = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
      flush  = (killed_cnt() < 3) && ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_load_stage.md
MEM_LOAD_STAGE -- requirements
Module: mem_load_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data-path width; legal values 32 or 64.
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL have parameter DEST_W, default 5, register-file address width.
REQ-004 SHALL define localparam OFF_W = log2(XLEN/8).
REQ-005 SHALL have ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill the held instruction and any pending load
- m1s_to_ms_valid  in  1  upstream valid
- ms_allowin  out  1  stage can accept
- in_pc  in  PC_W  instruction PC
- in_dest  in  DEST_W  write-back register
- in_gr_we  in  1  register write enable
- in_res_from_mem  in  1  instruction is a load
- in_load_op  in  4  load type
- in_addr_lo  in  OFF_W  low address bits
- in_rt_value  in  XLEN  old rt, for LWL/LWR
- in_alu_result  in  XLEN  ALU result
- in_ex  in  1  instruction carries an exception
- in_cp0_sel  in  1  result comes from CP0 (MFC0)
- in_cp0_data  in  XLEN  CP0 read data
- dcache_rvalid  in  1  one-cycle read-response pulse
- dcache_rdata  in  XLEN  read data, valid with dcache_rvalid
- ws_allowin  in  1  downstream can accept
- ms_to_ws_valid  out  1  downstream valid
- out_pc  out  PC_W
- out_dest  out  DEST_W
- out_gr_we  out  1
- out_ex  out  1
- out_result  out  XLEN  final write-back data
- fwd_dest  out  DEST_W  bypass address; 0 when stage empty
- fwd_result  out  XLEN  bypass data
- fwd_data_ok  out  1  fwd_result is final

Function
REQ-006 SHALL use a state register with states EMPTY, WAIT (load accepted, no response yet) and READY.
REQ-007 Acceptance SHALL occur when m1s_to_ms_valid && ms_allowin, with ms_allowin = (state==EMPTY) || (ms_to_ws_valid && ws_allowin).
- On accept, all in_* fields are registered.
- A load (in_res_from_mem && !in_ex) moves to WAIT.
- Every other instruction moves to READY.
REQ-008 Leaving the stage without a new accept SHALL return the state to EMPTY.
REQ-009 ms_to_ws_valid SHALL equal (state==READY).
REQ-010 In WAIT, a dcache_rvalid with drop_cnt==0 SHALL capture dcache_rdata into a data register and move to READY on the next cycle.
- Captured data is held until the instruction leaves, so a response arriving while ws_allowin=0 is never lost.
REQ-011 The response-to-ms_to_ws_valid latency SHALL be exactly 1 cycle.
REQ-012 Load formatting SHALL use the lane selected by in_addr_lo (little-endian), with byte/half/word lanes floor-aligned:
- 0 LB: sign-extend byte.
- 1 LBU: zero-extend byte.
- 2 LH: sign-extend half.
- 3 LHU: zero-extend half.
- 4 LW: sign-extend word.
- 5 LWU: zero-extend word.
- 6 LD: full 64 bits.
- 7 LWL / 8 LWR: MIPS semantics within the selected word, merged with in_rt_value; for XLEN=64, bit 2 selects the word and the result is sign-extended from bit 31.
- Others: raw data.
REQ-013 For XLEN=32, ops 5 and 6 SHALL behave as op 4.
REQ-014 out_result SHALL be the formatted load data for loads, in_cp0_data when in_cp0_sel is set, and in_alu_result otherwise.
REQ-015 fwd_dest SHALL equal out_dest when state != EMPTY && out_gr_we, and 0 otherwise.
- fwd_data_ok = (state==READY).
- fwd_result = out_result.
REQ-016 flush SHALL force state to EMPTY and block any accept in the same cycle.
- If flush hits in WAIT, drop_cnt (2-bit, saturating at 3) increments.
REQ-017 While drop_cnt > 0, each dcache_rvalid SHALL be discarded and decrement drop_cnt.
- If a flush and a discarded response occur in the same cycle, the net drop_cnt change is 0.
REQ-018 A dcache_rvalid in EMPTY or READY with drop_cnt==0 SHALL be ignored.
REQ-019 A response arriving in the same cycle a load is accepted SHALL NOT be attributed to that load.
REQ-020 Exception instructions (in_ex=1) SHALL never wait for dcache and SHALL pass with out_ex=1.

Reset
REQ-021 Reset SHALL set state=EMPTY, drop_cnt=0, all registered fields and the data register to 0, and ms_to_ws_valid, fwd_dest and fwd_data_ok to 0.
REQ-022 Reset SHALL take priority over flush and accept.
REQ-023 Responses arriving after reset for pre-reset loads SHALL be ignored.

Verification
REQ-024 LB, addr_lo=3, rdata=0x80FF_0000, XLEN=32 -> out_result=0xFFFF_FF80, ms_to_ws_valid 1 cycle after rvalid.
REQ-025 LWL, addr_lo=1, rdata=0x4433_2211, rt=0xAABB_CCDD -> out_result=0x2211_CCDD.
REQ-026 Load accepted, rvalid with rdata=0x1234 while ws_allowin=0 for 5 cycles -> ms_to_ws_valid held at 1, out_result stays 0x1234, ms_allowin=0 until ws_allowin=1.
REQ-027 Flush in WAIT, then a new LW accepted, then rvalid(0xDEAD), then rvalid(0xBEEF) -> first response discarded, out_result=0xBEEF.
REQ-028 XLEN=64, LWU, addr_lo=4, rdata=0xF000_0001_0000_0000 -> out_result=0x0000_0000_F000_0001.
REQ-029 Back-to-back ALU instructions with ws_allowin=1 -> one result per cycle, fwd_data_ok=1, fwd_dest tracks each dest.
